// File: rtl/mem_responder_if.sv
// Request/response bundle between the CPU control path and mem_responder.
// The CPU side uses the master modport; the responder uses the slave modport.
interface mem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  logic              ReqValid;
  logic              ReqWrite;
  logic [ADDR_W-1:0] ReqAddr;
  logic [DATA_W-1:0] ReqWData;
  logic              ReqReady;
  logic              RespValid;
  logic [DATA_W-1:0] RespRData;
  logic              Busy;
  logic              Err;

  modport master (
    output ReqValid, ReqWrite, ReqAddr, ReqWData,
    input  ReqReady, RespValid, RespRData, Busy, Err
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqAddr, ReqWData,
    output ReqReady, RespValid, RespRData, Busy, Err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder with WAIT_STATES wait cycles per access.
// Optional MEM_RANGE_CHECK_EN: addresses >= DEPTH are suppressed and flag Err.
module mem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 10,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input logic           CLK,
  input logic           Reset,
  mem_responder_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [IDX_W-1:0]  w_idx;
  logic              w_oor;
  logic              w_access;
  logic              w_wr_en;

  assign w_idx    = r_addr[IDX_W-1:0];
  assign w_access = (r_state == S_ACCESS);

`ifdef MEM_RANGE_CHECK_EN
  logic r_err;
  assign w_oor = ({1'b0, r_addr} >= (ADDR_W+1)'(DEPTH));
`else
  assign w_oor = 1'b0;
`endif

  assign w_wr_en = w_access && r_write && !w_oor;

  // Control FSM: accept in IDLE, count wait states, access, respond.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.ReqValid) begin
            r_write <= bus.ReqWrite;
            r_addr  <= bus.ReqAddr;
            r_wdata <= bus.ReqWData;
            if (WAIT_STATES > 0) begin
              r_cnt   <= 4'(WAIT_STATES);
              r_state <= S_WAIT;
            end else begin
              r_state <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= S_ACCESS;
        end
        S_ACCESS: r_state <= S_RESP;
        S_RESP:   r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Read data register: updated only by reads, holds across writes.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_rdata <= '0;
    end else if (w_access && !r_write) begin
      r_rdata <= w_oor ? '0 : r_mem[w_idx];
    end
  end

  // Storage array; never reset. Async reset drops ACCESS, so an aborted
  // write never reaches the array.
  always_ff @(posedge CLK) begin
    if (w_wr_en) r_mem[w_idx] <= r_wdata;
  end

`ifdef MEM_RANGE_CHECK_EN
  // Out-of-range flag captured at the access, shown only during RESP.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) r_err <= 1'b0;
    else if (w_access) r_err <= w_oor;
  end
  assign bus.Err = r_err && (r_state == S_RESP);
`else
  assign bus.Err = 1'b0;
`endif

  assign bus.ReqReady  = (r_state == S_IDLE);
  assign bus.Busy      = (r_state != S_IDLE);
  assign bus.RespValid = (r_state == S_RESP);
  assign bus.RespRData = r_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: timing, data, abort, aliasing.
// Define MEM_RANGE_CHECK_EN to check the range-check build.
module tb_mem_responder;

`ifdef MEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic CLK = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  mem_responder_if #(.DATA_W(16), .ADDR_W(10)) ia ();
  mem_responder_if #(.DATA_W(16), .ADDR_W(10)) ib ();

  mem_responder #(
    .DATA_W(16), .ADDR_W(10), .DEPTH(512), .WAIT_STATES(2)
  ) dut_a (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (ia.slave)
  );

  mem_responder #(
    .DATA_W(16), .ADDR_W(10), .DEPTH(1024), .WAIT_STATES(0)
  ) dut_b (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (ib.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic txn_a(input logic w, input logic [9:0] a,
                       input logic [15:0] d, input logic [9:0] alt,
                       output logic [15:0] rd, output logic er,
                       output int lat);
    int n;
    n = 0; lat = -1; rd = '0; er = 1'b0;
    @(negedge CLK);
    while (!ia.ReqReady && n < 20) begin
      @(negedge CLK);
      n++;
    end
    ia.ReqValid = 1'b1; ia.ReqWrite = w;
    ia.ReqAddr = a; ia.ReqWData = d;
    @(posedge CLK);
    #1;
    ia.ReqValid = 1'b0; ia.ReqAddr = alt; ia.ReqWData = ~d;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (ia.RespValid) begin
        rd = ia.RespRData; er = ia.Err; lat = k;
        break;
      end
    end
  endtask

  task automatic txn_b(input logic w, input logic [9:0] a,
                       input logic [15:0] d,
                       output logic [15:0] rd, output int lat);
    int n;
    n = 0; lat = -1; rd = '0;
    @(negedge CLK);
    while (!ib.ReqReady && n < 20) begin
      @(negedge CLK);
      n++;
    end
    ib.ReqValid = 1'b1; ib.ReqWrite = w;
    ib.ReqAddr = a; ib.ReqWData = d;
    @(posedge CLK);
    #1;
    ib.ReqValid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (ib.RespValid) begin
        rd = ib.RespRData; lat = k;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] rd;
    logic        er;
    int          lat;
    int          pulses;

    Reset = 1'b1;
    ia.ReqValid = 1'b0; ia.ReqWrite = 1'b0;
    ia.ReqAddr = '0;    ia.ReqWData = '0;
    ib.ReqValid = 1'b0; ib.ReqWrite = 1'b0;
    ib.ReqAddr = '0;    ib.ReqWData = '0;
    repeat (2) @(negedge CLK);

    chk("rst_ready", ia.ReqReady, 1);
    chk("rst_busy",  ia.Busy, 0);
    chk("rst_valid", ia.RespValid, 0);
    chk("rst_rdata", ia.RespRData, 0);
    chk("rst_err",   ia.Err, 0);
    chk("rst_b_ready", ib.ReqReady, 1);
    Reset = 1'b0;

    // Write 0xBEEF @0x005, cycle-accurate handshake timing.
    @(negedge CLK);
    ia.ReqValid = 1'b1; ia.ReqWrite = 1'b1;
    ia.ReqAddr = 10'h005; ia.ReqWData = 16'hBEEF;
    @(posedge CLK);
    #1;
    ia.ReqValid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk($sformatf("w1_valid_%0d", k), ia.RespValid, (k == 3));
      chk($sformatf("w1_ready_%0d", k), ia.ReqReady, (k == 4));
      chk($sformatf("w1_busy_%0d", k),  ia.Busy, (k != 4));
    end

    // Read back; data held after the pulse.
    txn_a(1'b0, 10'h005, 16'h0, 10'h005, rd, er, lat);
    chk("r1_lat", lat, 3);
    chk("r1_data", rd, 16'hBEEF);
    chk("r1_err", er, 0);
    @(negedge CLK);
    chk("r1_hold", ia.RespRData, 16'hBEEF);
    chk("r1_pulse_end", ia.RespValid, 0);

    // Address changed mid-transaction must not leak.
    txn_a(1'b1, 10'h006, 16'h1111, 10'h006, rd, er, lat);
    chk("w2_lat", lat, 3);
    txn_a(1'b0, 10'h005, 16'h0, 10'h006, rd, er, lat);
    chk("r2_addr_latched", rd, 16'hBEEF);
    txn_a(1'b0, 10'h006, 16'h0, 10'h006, rd, er, lat);
    chk("r3_data", rd, 16'h1111);

    // Reset during WAIT aborts a write.
    txn_a(1'b1, 10'h010, 16'h5555, 10'h010, rd, er, lat);
    chk("w3_lat", lat, 3);
    @(negedge CLK);
    ia.ReqValid = 1'b1; ia.ReqWrite = 1'b1;
    ia.ReqAddr = 10'h010; ia.ReqWData = 16'h1234;
    @(posedge CLK);
    #1;
    ia.ReqValid = 1'b0;
    @(negedge CLK);
    chk("ab_busy_pre", ia.Busy, 1);
    Reset = 1'b1;
    #1;
    chk("ab_ready", ia.ReqReady, 1);
    chk("ab_busy",  ia.Busy, 0);
    chk("ab_valid", ia.RespValid, 0);
    chk("ab_rdata", ia.RespRData, 0);
    chk("ab_err",   ia.Err, 0);
    pulses = 0;
    repeat (3) begin
      @(negedge CLK);
      if (ia.RespValid) pulses++;
    end
    Reset = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      if (ia.RespValid) pulses++;
    end
    chk("ab_no_resp", pulses, 0);
    txn_a(1'b0, 10'h010, 16'h0, 10'h010, rd, er, lat);
    chk("ab_old_data", rd, 16'h5555);

    // Aliasing / range check with DEPTH=512.
    txn_a(1'b1, 10'h000, 16'h0F0F, 10'h000, rd, er, lat);
    txn_a(1'b1, 10'h200, 16'hAAAA, 10'h200, rd, er, lat);
    chk("oor_w_err", er, RC);
    chk("oor_w_rdata", rd, 16'h5555);
    txn_a(1'b0, 10'h000, 16'h0, 10'h000, rd, er, lat);
    chk("alias_r0", rd, RC ? 16'h0F0F : 16'hAAAA);
    chk("alias_r0_err", er, 0);
    txn_a(1'b0, 10'h200, 16'h0, 10'h200, rd, er, lat);
    chk("oor_r_data", rd, RC ? 16'h0000 : 16'hAAAA);
    chk("oor_r_err", er, RC);
    @(negedge CLK);
    chk("oor_err_clr", ia.Err, 0);

    // Zero wait states: response the cycle after the access edge.
    txn_b(1'b1, 10'h003, 16'h7777, rd, lat);
    chk("b_w_lat", lat, 1);
    txn_b(1'b0, 10'h003, 16'h0, rd, lat);
    chk("b_r_lat", lat, 1);
    chk("b_r_data", rd, 16'h7777);
    @(negedge CLK);
    chk("b_ready_back", ib.ReqReady, 1);
    txn_b(1'b0, 10'h003, 16'h0, rd, lat);
    chk("b_r2_lat", lat, 1);
    chk("b_r2_data", rd, 16'h7777);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
